// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit: default operand
// width, op code constants and the FSM state encoding.
package muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_FINISH = 2'd2
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if
// Request/response bundle between the pipeline and muldiv_unit.
//   start, op, a, b           : request from the pipeline (master -> slave)
//   busy, done, div_by_zero   : status back to the pipeline
//   hi, lo                    : architectural HI/LO register contents
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step
// One radix-2 iteration of the multiply/divide engine, purely combinational.
//   acc_i    : multiply -> {partial product, remaining multiplier bits}
//              divide   -> {partial remainder, remaining dividend / quotient bits}
//   opnd_i   : multiplicand (multiply) or divisor (divide)
//   is_div_i : selects the restoring-divide step instead of shift-add
//   acc_o    : accumulator after this iteration
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    input  logic               is_div_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] trial;
    logic           ge;

    // Shift-add: the multiplier LSB sits at acc_i[0]; the carry out of the
    // upper-half add re-enters as the new MSB while everything shifts right.
    // Restoring divide: the WIDTH+1-bit trial remainder takes the next dividend
    // bit; the subtraction is kept only if it does not go negative. Since the
    // true difference is always below the divisor, a WIDTH-bit subtract suffices.
    always_comb begin
        sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, opnd_i};
        trial = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        ge    = (trial >= {1'b0, opnd_i});
        if (is_div_i) begin
            acc_o = {(ge ? (trial[WIDTH-1:0] - opnd_i) : trial[WIDTH-1:0]),
                     acc_i[WIDTH-2:0], ge};
        end else if (acc_i[0]) begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end else begin
            acc_o = {1'b0, acc_i[2*WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers. Operands are
// reduced to magnitudes, processed one bit per clock by muldiv_step, then
// sign-corrected and written to HI/LO with a one-cycle done pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : muldiv_if.slave (start/op/a/b in, busy/done/div_by_zero/hi/lo out)
// Optional feature macro: MULDIV_MTHILO_EN enables MTHI/MTLO direct writes;
// without it op 100/101 are ignored like the reserved codes.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);

    muldiv_state_e      state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               res_neg_q, res_neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               dbz_q, dbz_d;
    logic               hold_q, hold_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dbz_out_q, dbz_out_d;
`ifdef MULDIV_MTHILO_EN
    logic               mt_done_q, mt_done_d;
`endif

    logic               is_mul_op, is_div_op, signed_op;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [2*WIDTH-1:0] step_acc;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .is_div_i (is_div_q),
        .acc_o    (step_acc)
    );

    // Operand decode and magnitude extraction for the signed ops. The most
    // negative value maps to itself, which reads correctly as an unsigned
    // magnitude of 2^(WIDTH-1).
    always_comb begin
        is_mul_op = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
        is_div_op = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
        signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        a_neg     = signed_op & bus.a[WIDTH-1];
        b_neg     = signed_op & bus.b[WIDTH-1];
        a_abs     = a_neg ? -bus.a : bus.a;
        b_abs     = b_neg ? -bus.b : bus.b;
        prod_fix  = res_neg_q ? -acc_q : acc_q;
        quo_fix   = res_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix   = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    // Next-state logic for the FSM, iteration counter, HI/LO and outputs.
    // A divide by zero jumps straight to FINISH with the final HI/LO already
    // placed in the accumulator; hold_q keeps it there one extra cycle so its
    // done lands two edges after acceptance.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        dbz_d     = dbz_q;
        hold_d    = hold_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        dbz_out_d = 1'b0;
`ifdef MULDIV_MTHILO_EN
        mt_done_d = 1'b0;
        done_d    = mt_done_q;
`else
        done_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start && (is_mul_op || is_div_op)) begin
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    is_div_d  = is_div_op;
                    res_neg_d = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    if (is_div_op && (bus.b == '0)) begin
                        acc_d   = {bus.a, {WIDTH{1'b1}}};
                        dbz_d   = 1'b1;
                        hold_d  = 1'b1;
                        state_d = ST_FINISH;
                    end else begin
                        acc_d   = is_div_op ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
                        opnd_d  = is_div_op ? b_abs : a_abs;
                        dbz_d   = 1'b0;
                        hold_d  = 1'b0;
                        state_d = ST_CALC;
                    end
                end
`ifdef MULDIV_MTHILO_EN
                else if (bus.start && (bus.op == OP_MTHI)) begin
                    hi_d      = bus.a;
                    mt_done_d = 1'b1;
                end else if (bus.start && (bus.op == OP_MTLO)) begin
                    lo_d      = bus.a;
                    mt_done_d = 1'b1;
                end
`endif
            end
            ST_CALC: begin
                acc_d = step_acc;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                if (hold_q) begin
                    hold_d = 1'b0;
                end else begin
                    if (dbz_q) begin
                        hi_d = acc_q[2*WIDTH-1:WIDTH];
                        lo_d = acc_q[WIDTH-1:0];
                    end else if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                    done_d    = 1'b1;
                    dbz_out_d = dbz_q;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            dbz_q     <= 1'b0;
            hold_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
`ifdef MULDIV_MTHILO_EN
            mt_done_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            dbz_q     <= dbz_d;
            hold_q    <= hold_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_out_q <= dbz_out_d;
`ifdef MULDIV_MTHILO_EN
            mt_done_q <= mt_done_d;
`endif
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_out_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
// Self-checking bench for muldiv_unit (WIDTH=32). Expected HI/LO/div_by_zero
// values come from an arithmetic reference model and are queued when a request
// is issued, then popped and compared whenever the unit pulses done.
// Honours MULDIV_MTHILO_EN the same way the design does.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } result_t;

    logic        clk;
    logic        rst_n;
    int          checks;
    int          errors;
    result_t     sbQueue[$];
    logic [31:0] lastHi;
    logic [31:0] lastLo;
    logic [31:0] randA;
    logic [31:0] randB;
    logic [2:0]  randOp;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Reference model built on plain SV arithmetic.
    function automatic result_t modelOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        result_t     r;
        logic [63:0] p;
        longint      sa, sb;
        r.hi  = lastHi;
        r.lo  = lastLo;
        r.dbz = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_MULT: begin
                p = 64'(sa * sb);
                r.hi = p[63:32];
                r.lo = p[31:0];
            end
            OP_MULTU: begin
                p = 64'(a) * 64'(b);
                r.hi = p[63:32];
                r.lo = p[31:0];
            end
            OP_DIV, OP_DIVU: begin
                if (b == 32'd0) begin
                    r.hi  = a;
                    r.lo  = 32'hFFFF_FFFF;
                    r.dbz = 1'b1;
                end else if (op == OP_DIV) begin
                    r.lo = 32'(sa / sb);
                    r.hi = 32'(sa % sb);
                end else begin
                    r.lo = a / b;
                    r.hi = a % b;
                end
            end
            OP_MTHI: r.hi = a;
            OP_MTLO: r.lo = a;
            default: ;
        endcase
        return r;
    endfunction

    // Drives a request and queues its expected result if the unit will act on it.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        result_t r;
        logic    accepted;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        accepted  = (op <= OP_DIVU);
`ifdef MULDIV_MTHILO_EN
        accepted  = accepted || (op == OP_MTHI) || (op == OP_MTLO);
`endif
        if (accepted) begin
            r = modelOp(op, a, b);
            sbQueue.push_back(r);
            lastHi = r.hi;
            lastLo = r.lo;
        end
    endtask

    // Called right after driving a request: steps over the accept edge, then
    // counts edges until done (bounded), checking latency and busy occupancy.
    // injectAt >= 0 raises a MULT 2x2 start for one cycle while busy.
    task automatic waitDone(input string tag, input int expLatency, input logic expBusy,
                            input int injectAt, input logic checkPulse);
        int n;
        int busyCycles;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n = 0;
        checkOutput({tag, "_busy_after_e0"}, 64'(bus.busy), 64'(expBusy));
        busyCycles = int'(bus.busy);
        while (!bus.done && n < 100) begin
            if (n == injectAt) begin
                bus.op    = OP_MULT;
                bus.a     = 32'd2;
                bus.b     = 32'd2;
                bus.start = 1'b1;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            n++;
            if (bus.busy) busyCycles++;
        end
        checkOutput({tag, "_latency"}, 64'(n), 64'(expLatency));
        checkOutput({tag, "_busy_cycles"}, 64'(busyCycles), 64'(expBusy ? expLatency : 0));
        if (checkPulse) begin
            @(posedge clk);
            #1;
            checkOutput({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
            checkOutput({tag, "_dbz_pulse"}, 64'(bus.div_by_zero), 64'd0);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        result_t e;
        if (rst_n && bus.done) begin
            if (sbQueue.size() == 0) begin
                checkOutput("unexpected_done", 64'(bus.done), 64'd0);
            end else begin
                e = sbQueue.pop_front();
                checkOutput("sb_hi", 64'(bus.hi), 64'(e.hi));
                checkOutput("sb_lo", 64'(bus.lo), 64'(e.lo));
                checkOutput("sb_dbz", 64'(bus.div_by_zero), 64'(e.dbz));
            end
        end
    end

    // Ignored request (reserved op or disabled MTHI/MTLO): no done, no busy, HI unchanged.
    task automatic checkIgnored(input string tag, input logic [2:0] op);
        applyStimulus(op, 32'h0000_1234, 32'd0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput({tag, "_no_done"}, 64'(bus.done), 64'd0);
            checkOutput({tag, "_no_busy"}, 64'(bus.busy), 64'd0);
            @(posedge clk);
            #1;
        end
        checkOutput({tag, "_hi_kept"}, 64'(bus.hi), 64'(lastHi));
        checkOutput({tag, "_lo_kept"}, 64'(bus.lo), 64'(lastLo));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        lastHi    = 32'd0;
        lastLo    = 32'd0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_hi", 64'(bus.hi), 64'd0);
        checkOutput("rst_lo", 64'(bus.lo), 64'd0);
        checkOutput("rst_busy", 64'(bus.busy), 64'd0);
        checkOutput("rst_done", 64'(bus.done), 64'd0);
        checkOutput("rst_dbz", 64'(bus.div_by_zero), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        waitDone("mult_neg", 33, 1'b1, -1, 1'b1);

        // Back-to-back: the second request is raised in the done cycle.
        applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        waitDone("multu_max", 33, 1'b1, -1, 1'b0);
        applyStimulus(OP_MULTU, 32'd3, 32'd5);
        waitDone("multu_b2b", 33, 1'b1, -1, 1'b1);

        applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        waitDone("div_neg", 33, 1'b1, -1, 1'b1);
        applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        waitDone("div_ovf", 33, 1'b1, -1, 1'b1);
        applyStimulus(OP_DIVU, 32'd10, 32'd0);
        waitDone("divu_zero", 2, 1'b1, -1, 1'b1);
        applyStimulus(OP_DIV, 32'hFFFF_FFFB, 32'd0);
        waitDone("div_zero", 2, 1'b1, -1, 1'b1);

        for (int i = 0; i < 6; i++) begin
            randOp = 3'($urandom_range(0, 3));
            randA  = $urandom;
            randB  = (i == 3) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
            applyStimulus(randOp, randA, randB);
            waitDone("rand", (randOp >= OP_DIV && randB == 32'd0) ? 2 : 33, 1'b1, -1, 1'b1);
        end

        // A start while busy is dropped, not queued.
        applyStimulus(OP_DIVU, 32'd100, 32'd7);
        waitDone("busy_ignore", 33, 1'b1, 5, 1'b1);

`ifdef MULDIV_MTHILO_EN
        applyStimulus(OP_MTHI, 32'h0000_1234, 32'd0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkOutput("mthi_hi", 64'(bus.hi), 64'h1234);
        checkOutput("mthi_busy", 64'(bus.busy), 64'd0);
        checkOutput("mthi_done_early", 64'(bus.done), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("mthi_done", 64'(bus.done), 64'd1);
        checkOutput("mthi_busy2", 64'(bus.busy), 64'd0);
        applyStimulus(OP_MTLO, 32'h0000_5678, 32'd0);
        waitDone("mtlo", 1, 1'b0, -1, 1'b1);
        checkOutput("mtlo_lo", 64'(bus.lo), 64'h5678);
`else
        checkIgnored("mthi_off", OP_MTHI);
        checkIgnored("mtlo_off", OP_MTLO);
`endif
        checkIgnored("reserved", 3'b110);

        // Asynchronous reset in the middle of a divide.
        applyStimulus(OP_DIVU, 32'd100, 32'd7);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        sbQueue.delete();
        lastHi = 32'd0;
        lastLo = 32'd0;
        checkOutput("abort_hi", 64'(bus.hi), 64'd0);
        checkOutput("abort_lo", 64'(bus.lo), 64'd0);
        checkOutput("abort_busy", 64'(bus.busy), 64'd0);
        checkOutput("abort_done", 64'(bus.done), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_abort_busy", 64'(bus.busy), 64'd0);
        applyStimulus(OP_MULTU, 32'd3, 32'd5);
        waitDone("recover", 33, 1'b1, -1, 1'b1);

        checkOutput("sb_empty", 64'(sbQueue.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the MIPS datapath, sitting beside the combinational ALU and owning the architectural HI/LO registers. It executes MULT, MULTU, DIV and DIVU over a parametrised operand width using a radix-2 shift-add / restoring-divide engine, one bit per clock. A start/busy/done handshake lets the pipeline stall on MFHI/MFLO until the result is ready.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; WIDTH ≥ 4, power of two.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only while busy=0.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 reserved.
- a  in  WIDTH  multiplicand / dividend / MTHI-MTLO data.
- b  in  WIDTH  multiplier / divisor.
- busy  out  1  operation in flight; start is ignored while high.
- done  out  1  one-cycle pulse; hi/lo hold the new result in the same cycle.
- div_by_zero  out  1  pulses with done when DIV/DIVU had b=0; otherwise 0.
- hi  out  WIDTH  HI register: product upper half or remainder.
- lo  out  WIDTH  LO register: product lower half or quotient.

## Operation
- FSM states: IDLE, CALC, FINISH.
- IDLE, start=1, legal op:
  - Latch |a| and |b| for signed ops, and the raw values for unsigned ops.
  - Latch result sign, remainder sign and op.
  - Clear the iteration counter, which is $clog2(WIDTH) bits.
  - Go to CALC; busy=1.
- Reserved op codes are ignored: no state change, no done.
- CALC: one iteration per cycle for exactly WIDTH cycles; then go to FINISH.
  - Multiply: 2·WIDTH-bit accumulator, shift-add on the LSB of the multiplier.
  - Divide: restoring step on a WIDTH+1-bit partial remainder.
- FINISH:
  - Apply sign correction.
  - Write hi/lo, pulse done, drop busy.
  - Return to IDLE.
- Signed multiply: the full 2·WIDTH-bit two's-complement product; hi holds the upper half.
- Signed divide:
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Most-negative ÷ −1: lo = most-negative (wraps), hi = 0, no flag.
- Divide by zero (DIV or DIVU, b=0):
  - Skip CALC: IDLE → FINISH directly.
  - Result: lo = all ones, hi = a unchanged, div_by_zero=1 with done.
- hi/lo change only at FINISH (or at an MTHI/MTLO write). They hold their old value throughout CALC.

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0, div_by_zero=0, state IDLE.
- Reset asserted mid-operation aborts the operation immediately; all outputs return to their reset values.
- Let E0 be the edge at which start is accepted. busy=1 after E0.
- Normal op: FINISH is occupied after edge E0+WIDTH. done=1 and new hi/lo are visible after edge E0+WIDTH+1; busy=0 in that same cycle.
- Divide by zero: done after edge E0+2.
- Back-to-back: start in the done cycle is accepted, with zero bubble.
- start while busy=1: dropped, not queued.
- done and div_by_zero are strictly single-cycle pulses.

## Configuration
- MULDIV_MTHILO_EN defined:
  - op 100 writes a to hi, and op 101 writes a to lo, at E0.
  - done pulses the next cycle; busy stays 0.
- MULDIV_MTHILO_EN undefined: op 100/101 are treated as reserved and ignored, so hi/lo are reachable only through mul/div results.

## Structure
- Shared package muldiv_pkg holds:
  - op code constants (OP_MULT … OP_MTLO);
  - FSM state encoding;
  - default WIDTH.
- One sub-module, muldiv_step: a combinational single-iteration datapath.
  - Inputs: accumulator/remainder, operand and op class.
  - Output: next accumulator/remainder.
  - Instantiated once.
- FSM, counter, sign fix-up and HI/LO stay in muldiv_unit.

## Test plan
- MULT a=0xFFFFFFFD, b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB; done after edge E0+33; busy high for exactly 33 cycles.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. An immediately following start in the done cycle (MULTU 3×5) → hi=0, lo=15.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 ÷ 0xFFFFFFFF → lo=0x80000000, hi=0, div_by_zero=0.
- DIVU a=10, b=0 → done after E0+2, div_by_zero=1, lo=0xFFFFFFFF, hi=0x0000000A.
- Busy and reset behaviour:
  - DIVU 100/7 started; a second start (MULT 2×2) at cycle 5 is ignored → hi=2, lo=14.
  - Repeat the DIVU and pull rst_n low at cycle 10 → hi=lo=0, busy=0 asynchronously.
- With MULDIV_MTHILO_EN: MTHI 0x1234 → hi=0x1234 after E0, done next cycle, busy never high. Without the macro: hi unchanged, no done.
